// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared FSM state type, default width and full-subtractor bit helper
package serial_pkg;

    localparam int SERIAL_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    typedef struct packed {
        logic borrow;
        logic diff;
    } sub_bit_t;

    // One bit of a ripple subtractor: difference bit and outgoing borrow.
    function automatic sub_bit_t sub_bit(input logic a0, input logic b0, input logic bw);
        sub_bit_t r;
        r.diff   = a0 ^ b0 ^ bw;
        r.borrow = (~a0 & b0) | (~(a0 ^ b0) & bw);
        return r;
    endfunction

endpackage

// File: rtl/shift_reg_ple.sv
// rtl/shift_reg_ple.sv - shift register with parallel load, shift enable, serial-in at MSB, shifting right
module shift_reg_ple #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             serial_in,
    output logic [WIDTH-1:0] value
);

    // Load wins over shift so a new operation never inherits a half-shifted word.
    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (enable) begin
            value <= {serial_in, value[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor; SERIAL_SUB_SIGNED_OVF_EN adds a signed overflow output
module serial_subtractor
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             overflow,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);

    serial_state_t  state;
    serial_state_t  state_next;
    logic [CW-1:0]  count;
    logic           bw;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic           accept;
    logic           step;
    logic           last_step;
    sub_bit_t       bit_res;
    logic           unused_upper;

    assign accept    = (state == IDLE) && start;
    assign step      = (state == RUN);
    assign last_step = step && (count == CW'(1));
    assign bit_res   = sub_bit(a_q[0], b_q[0], bw);

    // Only the LSB of each operand register feeds the datapath.
    assign unused_upper = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            bw         <= 1'b0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            count <= CW'(WIDTH);
            bw    <= 1'b0;
        end else if (step) begin
            count <= count - CW'(1);
            bw    <= bit_res.borrow;
            if (last_step) begin
                borrow_out <= bit_res.borrow;
            end
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // On the last step the operand LSBs are the original sign bits and d is the result sign.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (last_step) begin
            overflow <= (a_q[0] != b_q[0]) && (bit_res.diff != a_q[0]);
        end
    end
`endif

    shift_reg_ple #(.WIDTH(WIDTH)) a_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (a),
        .enable     (step),
        .serial_in  (1'b0),
        .value      (a_q)
    );

    shift_reg_ple #(.WIDTH(WIDTH)) b_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (b),
        .enable     (step),
        .serial_in  (1'b0),
        .value      (b_q)
    );

    shift_reg_ple #(.WIDTH(WIDTH)) diff_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value ('0),
        .enable     (step),
        .serial_in  (bit_res.diff),
        .value      (diff)
    );

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - table, directed and random checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
    import serial_pkg::*;

    localparam int W = SERIAL_WIDTH;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         overflow;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    serial_subtractor #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .overflow   (overflow),
`endif
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        int   full = 1 << W;
        int   sx = (int'(x) >= full / 2) ? int'(x) - full : int'(x);
        int   sy = (int'(y) >= full / 2) ? int'(y) - full : int'(y);
        int   sd = sx - sy;
        r.d  = W'((int'(x) - int'(y) + full) % full);
        r.bo = (x < y);
        r.ov = (sd < -(full / 2)) || (sd > full / 2 - 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Start one operation from IDLE, wait for done and step once more into IDLE.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          output logic [W-1:0] r_diff, output logic r_borrow, output logic r_ovf,
                          output int lat, output int done_cycle);
        a = op_a;
        b = op_b;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        lat = -1;
        for (int i = 1; i <= 4 * W; i++) begin
            tick;
            if (done) begin
                lat = i;
                break;
            end
        end
        done_cycle = cycle;
        r_diff   = diff;
        r_borrow = borrow_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        r_ovf = overflow;
`else
        r_ovf = 1'b0;
`endif
        tick;
        check("done_one_cycle", {busy, done}, 2'b00);
    endtask

    vec_t         tbl[10];
    logic [W-1:0] rd;
    logic         rb;
    logic         ro;
    int           lat;
    int           dc;
    int           prev_dc;
    int           pulses;
    res_t         exp_r;
    logic [W-1:0] x;
    logic [W-1:0] y;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{a: 8'd100,  b: 8'd37,   d: 8'd63,   bo: 1'b0, ov: 1'b0};
        tbl[1] = '{a: 8'd5,    b: 8'd9,    d: 8'hFC,   bo: 1'b1, ov: 1'b0};
        tbl[2] = '{a: 8'h80,   b: 8'h01,   d: 8'h7F,   bo: 1'b0, ov: 1'b1};
        tbl[3] = '{a: 8'h7F,   b: 8'h01,   d: 8'h7E,   bo: 1'b0, ov: 1'b0};
        tbl[4] = '{a: 8'd0,    b: 8'd0,    d: 8'd0,    bo: 1'b0, ov: 1'b0};
        tbl[5] = '{a: 8'd255,  b: 8'd254,  d: 8'd1,    bo: 1'b0, ov: 1'b0};
        tbl[6] = '{a: 8'd0,    b: 8'd1,    d: 8'hFF,   bo: 1'b1, ov: 1'b0};
        tbl[7] = '{a: 8'h55,   b: 8'h55,   d: 8'd0,    bo: 1'b0, ov: 1'b0};
        tbl[8] = '{a: 8'h01,   b: 8'h80,   d: 8'h81,   bo: 1'b1, ov: 1'b1};
        tbl[9] = '{a: 8'h80,   b: 8'h7F,   d: 8'h01,   bo: 1'b0, ov: 1'b1};

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick;
        tick;
        check("reset_diff", diff, 0);
        check("reset_borrow", borrow_out, 0);
        check("reset_busy_done", {busy, done}, 2'b00);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("reset_overflow", overflow, 0);
`endif

        // Reset has priority over a simultaneous start.
        start = 1'b1;
        a = 8'd9;
        b = 8'd3;
        tick;
        reset = 1'b0;
        start = 1'b0;
        check("reset_beats_start", busy, 1'b0);
        tick;
        check("reset_beats_start_idle", {busy, done}, 2'b00);

        prev_dc = 0;
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, rd, rb, ro, lat, dc);
            check($sformatf("tbl%0d_diff", i), rd, tbl[i].d);
            check($sformatf("tbl%0d_borrow", i), rb, tbl[i].bo);
            check($sformatf("tbl%0d_latency", i), lat, W);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            check($sformatf("tbl%0d_overflow", i), ro, tbl[i].ov);
`endif
            if (i > 0) check($sformatf("tbl%0d_b2b_period", i), dc - prev_dc, W + 2);
            prev_dc = dc;
        end

        for (int i = 0; i < 3; i++) tick;
        check("hold_diff", diff, tbl[9].d);
        check("hold_borrow", borrow_out, tbl[9].bo);

        // Start pulsed with new operands mid-RUN must be ignored.
        a = 8'd100;
        b = 8'd37;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 4 * W; i++) begin
            if (i == 3) begin
                start = 1'b1;
                a = 8'd1;
                b = 8'd200;
            end
            tick;
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("ignore_start_latency", lat, W);
        check("ignore_start_diff", diff, 8'd63);
        check("ignore_start_borrow", borrow_out, 1'b0);
        tick;
        check("ignore_start_no_requeue", busy, 1'b0);

        // Leave borrow_out=1 so the mid-RUN reset has something to clear.
        run_op(8'd5, 8'd9, rd, rb, ro, lat, dc);
        check("pre_reset_borrow", rb, 1'b1);
        a = 8'd200;
        b = 8'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrun_reset_diff", diff, 0);
        check("midrun_reset_borrow", borrow_out, 0);
        check("midrun_reset_busy_done", {busy, done}, 2'b00);
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick;
            if (done) pulses++;
        end
        check("midrun_reset_no_done", pulses, 0);
        run_op(8'd0, 8'd1, rd, rb, ro, lat, dc);
        check("after_reset_diff", rd, 8'hFF);
        check("after_reset_borrow", rb, 1'b1);
        check("after_reset_latency", lat, W);

        for (int n = 0; n < 150; n++) begin
            x = W'($urandom);
            y = (n % 10 == 0) ? x : W'($urandom);
            exp_r = model(x, y);
            run_op(x, y, rd, rb, ro, lat, dc);
            check($sformatf("rand%0d_diff a=%0h b=%0h", n, x, y), rd, exp_r.d);
            check($sformatf("rand%0d_borrow", n), rb, exp_r.bo);
            check($sformatf("rand%0d_latency", n), lat, W);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            check($sformatf("rand%0d_overflow", n), ro, exp_r.ov);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
